// File: rtl/cache_fill_if.sv
// Handshake bundle between the cache miss controller, the cache arrays and main memory.
interface cache_fill_if;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic        fsm_busy;
  logic        mem_read;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_index;
  logic        write_tag_array;
  logic [8:0]  meta_wdata;

  modport master (
    output miss_detected, miss_address, memory_data_valid,
    input  fsm_busy, mem_read, memory_address, write_data_array,
    input  word_index, write_tag_array, meta_wdata
  );

  modport slave (
    input  miss_detected, miss_address, memory_data_valid,
    output fsm_busy, mem_read, memory_address, write_data_array,
    output word_index, write_tag_array, meta_wdata
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues WORDS sequential word reads, steers returned
// words into the data array, then strobes the metadata word for the filled line.
module cache_fill_fsm #(
  parameter int unsigned WORDS = 8
) (
  input logic         clk,
  input logic         rst,
  cache_fill_if.slave bus
);
  localparam int unsigned CW = $clog2(WORDS);
  localparam int unsigned BW = 16 - CW - 1;
  localparam logic [CW:0]   WORDS_C = (CW+1)'(WORDS);
  localparam logic [CW:0]   ONE_I   = (CW+1)'(1);
  localparam logic [CW-1:0] ONE_R   = CW'(1);
  localparam logic [CW-1:0] LAST_R  = CW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, FILL, TAG_WR} state_t;

  state_t        state, state_nx;
  logic [BW-1:0] blk_addr;
  logic          meta_valid;
  logic [CW:0]   issue_cnt;
  logic [CW-1:0] recv_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      blk_addr   <= '0;
      meta_valid <= 1'b0;
      issue_cnt  <= '0;
      recv_cnt   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.miss_detected) begin
            blk_addr   <= bus.miss_address[15:CW+1];
            meta_valid <= 1'b1;
            issue_cnt  <= '0;
            recv_cnt   <= '0;
          end
        end
        FILL: begin
          if (issue_cnt < WORDS_C) issue_cnt <= issue_cnt + ONE_I;
          if (bus.memory_data_valid) recv_cnt <= recv_cnt + ONE_R;
        end
        default: ;
      endcase
    end
  end

  // meta_valid keeps meta_wdata at zero from reset until the first miss is latched.
  always_comb begin
    state_nx             = state;
    bus.fsm_busy         = 1'b0;
    bus.mem_read         = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.word_index       = '0;
    bus.write_tag_array  = 1'b0;
    bus.meta_wdata       = {meta_valid, 1'b0, blk_addr[BW-1 -: 7]};
    case (state)
      IDLE: begin
        if (bus.miss_detected) state_nx = FILL;
      end
      FILL: begin
        bus.fsm_busy         = 1'b1;
        bus.mem_read         = (issue_cnt < WORDS_C);
        if (bus.mem_read) bus.memory_address = {blk_addr, issue_cnt[CW-1:0], 1'b0};
        bus.write_data_array = bus.memory_data_valid;
        bus.word_index       = 3'(recv_cnt);
        if (bus.memory_data_valid && recv_cnt == LAST_R) state_nx = TAG_WR;
      end
      TAG_WR: begin
        bus.fsm_busy        = 1'b1;
        bus.write_tag_array = 1'b1;
        state_nx            = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule
